// File: rtl/dram_port_arbiter_pkg.sv
// Shared types for the two-slot data-RAM port arbiter: FSM encoding, request
// payload and load-response owner tags.
package dram_port_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_SEL_W  = ARB_DATA_W / 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_HOLD2 = 1'b1
  } arb_state_e;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_P1   = 2'd1;
  localparam owner_t OWN_P2   = 2'd2;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_SEL_W-1:0]  sel;
    logic [ARB_DATA_W-1:0] wdata;
  } req_t;

  // Stores never return data, so they carry no owner.
  function automatic owner_t load_owner(input logic we, input owner_t slot);
    return we ? OWN_NONE : slot;
  endfunction

endpackage

// File: rtl/dram_req_slot.sv
// Single-entry hold register for the deferred slot-2 request.
module dram_req_slot
  import dram_port_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic clear,
  input  req_t din,
  output logic valid,
  output req_t payload
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid   <= 1'b0;
      payload <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      payload <= din;
    end else if (clear) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Two-slot arbiter onto a single-port data RAM; slot 1 wins ties, slot 2 is
// held one cycle. Optional statistics counters under DRAM_ARB_STATS_EN.
// Payload widths are bounded by the package widths.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned DATA_W = ARB_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic                  p1_we,
  input  logic [ADDR_W-1:0]     p1_addr,
  input  logic [DATA_W/8-1:0]   p1_sel,
  input  logic [DATA_W-1:0]     p1_wdata,
  output logic                  p1_rvalid,
  output logic [DATA_W-1:0]     p1_rdata,
  input  logic                  p2_valid,
  output logic                  p2_ready,
  input  logic                  p2_we,
  input  logic [ADDR_W-1:0]     p2_addr,
  input  logic [DATA_W/8-1:0]   p2_sel,
  input  logic [DATA_W-1:0]     p2_wdata,
  output logic                  p2_rvalid,
  output logic [DATA_W-1:0]     p2_rdata,
`ifdef DRAM_ARB_STATS_EN
  output logic [31:0]           stat_conflicts,
  output logic [31:0]           stat_grants,
`endif
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W/8-1:0]   ram_sel,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  localparam int unsigned SEL_W = DATA_W / 8;

  arb_state_e state, state_next;
  req_t       p1_req, p2_req, held, cmd;
  logic       held_valid, hold_load, hold_clear, issue;
  owner_t     tag, owner_next;

  assign p1_req = '{we: p1_we, addr: ARB_ADDR_W'(p1_addr), sel: ARB_SEL_W'(p1_sel),
                    wdata: ARB_DATA_W'(p1_wdata)};
  assign p2_req = '{we: p2_we, addr: ARB_ADDR_W'(p2_addr), sel: ARB_SEL_W'(p2_sel),
                    wdata: ARB_DATA_W'(p2_wdata)};

  dram_req_slot u_hold (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (hold_load),
    .clear   (hold_clear),
    .din     (p2_req),
    .valid   (held_valid),
    .payload (held)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Command select; everything is forced quiet while reset is asserted.
  always_comb begin
    state_next = state;
    p1_ready   = 1'b0;
    p2_ready   = 1'b0;
    issue      = 1'b0;
    cmd        = '0;
    owner_next = OWN_NONE;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    if (reset_n) begin
      unique case (state)
        ST_IDLE: begin
          if (p1_valid) begin
            issue      = 1'b1;
            cmd        = p1_req;
            p1_ready   = 1'b1;
            owner_next = load_owner(p1_we, OWN_P1);
            if (p2_valid) begin
              p2_ready   = 1'b1;
              hold_load  = 1'b1;
              state_next = ST_HOLD2;
            end
          end else if (p2_valid) begin
            issue      = 1'b1;
            cmd        = p2_req;
            p2_ready   = 1'b1;
            owner_next = load_owner(p2_we, OWN_P2);
          end
        end
        ST_HOLD2: begin
          issue      = held_valid;
          cmd        = held_valid ? held : '0;
          owner_next = held_valid ? load_owner(held.we, OWN_P2) : OWN_NONE;
          hold_clear = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign ram_ce    = issue;
  assign ram_we    = issue & cmd.we;
  assign ram_addr  = ADDR_W'(cmd.addr);
  assign ram_sel   = SEL_W'(cmd.sel);
  assign ram_wdata = DATA_W'(cmd.wdata);

  // Owner of the load whose data arrives on ram_rdata next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) tag <= OWN_NONE;
    else          tag <= owner_next;
  end

  assign p1_rvalid = (tag == OWN_P1);
  assign p2_rvalid = (tag == OWN_P2);
  assign p1_rdata  = p1_rvalid ? ram_rdata : '0;
  assign p2_rdata  = p2_rvalid ? ram_rdata : '0;

`ifdef DRAM_ARB_STATS_EN
  logic conflict;
  assign conflict = (state == ST_IDLE) && (state_next == ST_HOLD2);

  // Saturating event counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_conflicts <= '0;
      stat_grants    <= '0;
    end else begin
      if (conflict && (stat_conflicts != 32'hFFFF_FFFF)) stat_conflicts <= stat_conflicts + 32'd1;
      if (issue && (stat_grants != 32'hFFFF_FFFF))       stat_grants    <= stat_grants + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter with a small byte-enabled RAM model.
`timescale 1ns/1ps
module tb_dram_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        p1_valid, p1_ready, p1_we, p1_rvalid;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [3:0]  p1_sel;
  logic        p2_valid, p2_ready, p2_we, p2_rvalid;
  logic [31:0] p2_addr, p2_wdata, p2_rdata;
  logic [3:0]  p2_sel;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic [3:0]  ram_sel;
`ifdef DRAM_ARB_STATS_EN
  logic [31:0] stat_conflicts, stat_grants;
`endif

  logic [31:0] mem [256];
  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  dram_port_arbiter dut (
    .clock (clock), .reset_n (reset_n),
    .p1_valid (p1_valid), .p1_ready (p1_ready), .p1_we (p1_we), .p1_addr (p1_addr),
    .p1_sel (p1_sel), .p1_wdata (p1_wdata), .p1_rvalid (p1_rvalid), .p1_rdata (p1_rdata),
    .p2_valid (p2_valid), .p2_ready (p2_ready), .p2_we (p2_we), .p2_addr (p2_addr),
    .p2_sel (p2_sel), .p2_wdata (p2_wdata), .p2_rvalid (p2_rvalid), .p2_rdata (p2_rdata),
`ifdef DRAM_ARB_STATS_EN
    .stat_conflicts (stat_conflicts), .stat_grants (stat_grants),
`endif
    .ram_ce (ram_ce), .ram_we (ram_we), .ram_addr (ram_addr), .ram_sel (ram_sel),
    .ram_wdata (ram_wdata), .ram_rdata (ram_rdata)
  );

  // Single-port RAM: read data one cycle after a read command.
  always @(posedge clock) begin
    if (ram_ce) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[9:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_p1(input logic v, input logic we, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d);
    p1_valid = v; p1_we = we; p1_addr = a; p1_sel = s; p1_wdata = d;
  endtask

  task automatic drive_p2(input logic v, input logic we, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d);
    p2_valid = v; p2_we = we; p2_addr = a; p2_sel = s; p2_wdata = d;
  endtask

  task automatic idle_inputs();
    drive_p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive_p2(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  logic [31:0] exp_addr  [5] = '{32'h200, 32'h208, 32'h220, 32'h228, 32'h0};
  logic        exp_ready [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] exp_p1d   [5] = '{32'h0, 32'hA000_0080, 32'h0, 32'hA000_0088, 32'h0};
  logic [31:0] exp_p2d   [5] = '{32'h0, 32'h0, 32'hA000_0082, 32'h0, 32'hA000_008A};

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);

    // Requests during reset are ignored
    tick();
    drive_p1(1'b1, 1'b0, 32'h1c00_0010, 4'hF, 32'h0);
    #1;
    check("rst_ce", ram_ce, 1'b0);
    check("rst_p1_ready", p1_ready, 1'b0);
    check("rst_addr", ram_addr, 32'h0);
    idle_inputs();
    reset_n = 1'b1;

    // Idle bus
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("idle_ce", ram_ce, 1'b0);
      check("idle_addr_wdata", {ram_addr, ram_wdata}, 64'h0);
      check("idle_we_sel", {ram_we, ram_sel}, 5'h0);
    end

    // Single p1 load
    tick();
    drive_p1(1'b1, 1'b0, 32'h1c00_0010, 4'hF, 32'h0);
    #1;
    check("ld_ce", ram_ce, 1'b1);
    check("ld_we", ram_we, 1'b0);
    check("ld_addr", ram_addr, 32'h1c00_0010);
    check("ld_p1_ready", p1_ready, 1'b1);
    check("ld_p2_ready", p2_ready, 1'b0);
    tick();
    idle_inputs();
    #1;
    check("ld_p1_rvalid", p1_rvalid, 1'b1);
    check("ld_p1_rdata", p1_rdata, 32'hA000_0004);
    check("ld_p2_rvalid", p2_rvalid, 1'b0);
    check("ld_p2_rdata", p2_rdata, 32'h0);

    // Same-cycle store (p1) then load (p2) to one word
    tick();
    drive_p1(1'b1, 1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF);
    drive_p2(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    #1;
    check("st_ce", ram_ce, 1'b1);
    check("st_we", ram_we, 1'b1);
    check("st_addr", ram_addr, 32'h100);
    check("st_wdata", ram_wdata, 32'hDEAD_BEEF);
    check("st_ready", {p1_ready, p2_ready}, 2'b11);
    tick(); #1;
    check("hold_ce", ram_ce, 1'b1);
    check("hold_we", ram_we, 1'b0);
    check("hold_addr", ram_addr, 32'h100);
    check("hold_ready", {p1_ready, p2_ready}, 2'b00);
    check("hold_p1_rvalid", p1_rvalid, 1'b0);
    idle_inputs();
    tick(); #1;
    check("raw_p2_rvalid", p2_rvalid, 1'b1);
    check("raw_p2_rdata", p2_rdata, 32'hDEAD_BEEF);
    check("raw_p1_rvalid", p1_rvalid, 1'b0);
    check("raw_ce", ram_ce, 1'b0);

    // Back-to-back conflicts: p1, p2, p1, p2
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k < 4) begin
        drive_p1(1'b1, 1'b0, 32'h200 + 32'(16 * k), 4'hF, 32'h0);
        drive_p2(1'b1, 1'b0, 32'h208 + 32'(16 * k), 4'hF, 32'h0);
      end else begin
        idle_inputs();
      end
      #1;
      check("b2b_p1_ready", p1_ready, exp_ready[k]);
      check("b2b_p2_ready", p2_ready, exp_ready[k]);
      check("b2b_addr", ram_addr, exp_addr[k]);
      check("b2b_p1_rdata", {p1_rvalid, p1_rdata}, {exp_p1d[k] != 32'h0, exp_p1d[k]});
      check("b2b_p2_rdata", {p2_rvalid, p2_rdata}, {exp_p2d[k] != 32'h0, exp_p2d[k]});
    end

    // Store with no byte enables still issues, no response
    tick();
    drive_p1(1'b1, 1'b1, 32'h40, 4'h0, 32'h1234_5678);
    #1;
    check("sel0_ce_we", {ram_ce, ram_we}, 2'b11);
    check("sel0_sel", ram_sel, 4'h0);
    check("sel0_ready", p1_ready, 1'b1);
    tick();
    idle_inputs();
    #1;
    check("sel0_rvalid", {p1_rvalid, p2_rvalid}, 2'b00);
    check("sel0_idle_ce", ram_ce, 1'b0);

    // Reset in HOLD2 drops the held load and the pending p1 response
    tick();
    drive_p1(1'b1, 1'b0, 32'h1c00_0010, 4'hF, 32'h0);
    drive_p2(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    #1;
    check("rh_ready", {p1_ready, p2_ready}, 2'b11);
    tick();
    idle_inputs();
    #1;
    check("rh_hold_ce", ram_ce, 1'b1);
    check("rh_p1_rvalid_pre", p1_rvalid, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rh_ce", ram_ce, 1'b0);
    check("rh_p1_rvalid", p1_rvalid, 1'b0);
    check("rh_p1_rdata", p1_rdata, 32'h0);
    tick();
    reset_n = 1'b1;
    #1;
    check("rh_rel_ce", ram_ce, 1'b0);
    check("rh_rel_p2_rvalid", p2_rvalid, 1'b0);
    tick(); #1;
    check("rh_after_rvalid", {p1_rvalid, p2_rvalid}, 2'b00);
    check("rh_after_ce", ram_ce, 1'b0);

    // Back in IDLE: two single grants, then three conflicts
    tick();
    drive_p1(1'b1, 1'b1, 32'h300, 4'hF, 32'h55);
    #1;
    check("post_p1_ready", p1_ready, 1'b1);
    check("post_p1_ce", ram_ce, 1'b1);
    tick();
    idle_inputs();
    drive_p2(1'b1, 1'b1, 32'h304, 4'hF, 32'h66);
    #1;
    check("post_p2_ready", p2_ready, 1'b1);
    check("post_p2_addr", ram_addr, 32'h304);
    tick();
    drive_p1(1'b1, 1'b1, 32'h310, 4'hF, 32'h77);
    drive_p2(1'b1, 1'b1, 32'h314, 4'hF, 32'h88);
    repeat (6) tick();
    idle_inputs();
    tick(); #1;
    check("end_ce", ram_ce, 1'b0);
`ifdef DRAM_ARB_STATS_EN
    check("stat_conflicts", stat_conflicts, 32'd3);
    check("stat_grants", stat_grants, 32'd8);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dram_port_arbiter.md
DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, data-RAM byte address width.
REQ-002 Parameter DATA_W, default 32, data word width; sel width is DATA_W/8.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 pN_valid  in  1  request valid from issue slot N (N=1 older, N=2 younger).
REQ-006 pN_ready  out  1  slot N request accepted this cycle.
REQ-007 pN_we  in  1  1=store, 0=load.
REQ-008 pN_addr  in  ADDR_W  byte address.
REQ-009 pN_sel  in  DATA_W/8  byte enables.
REQ-010 pN_wdata  in  DATA_W  store data.
REQ-011 pN_rvalid  out  1  load data valid for slot N.
REQ-012 pN_rdata  out  DATA_W  load data for slot N.
REQ-013 ram_ce, ram_we  out  1 each  single-port RAM enable, write enable.
REQ-014 ram_addr, ram_sel, ram_wdata  out  ADDR_W, DATA_W/8, DATA_W  RAM command.
REQ-015 ram_rdata  in  DATA_W  RAM read data, valid exactly 1 cycle after a ce=1, we=0 command.

Function
REQ-016 The block SHALL issue at most one RAM command per cycle.
REQ-017 FSM states: IDLE, HOLD2. Reset state IDLE.
REQ-018 IDLE, only p1_valid: issue p1 combinationally, p1_ready=1; stay IDLE.
REQ-019 IDLE, only p2_valid: issue p2, p2_ready=1; stay IDLE.
REQ-020 IDLE, both valid: issue p1; capture p2 into the hold register; p1_ready=p2_ready=1; go to HOLD2.
REQ-021 HOLD2: issue held p2 command; p1_ready=p2_ready=0 regardless of inputs; return to IDLE next cycle.
REQ-022 Program order SHALL be preserved: slot-1 access always reaches RAM no later than the same-cycle slot-2 access, so a slot-1 store followed by a slot-2 load to the same word returns the stored data.
REQ-023 A response tag register SHALL record the owner of each issued load; pN_rvalid=1 and pN_rdata=ram_rdata in the cycle after issue for the owner only.
REQ-024 Stores SHALL produce no rvalid.
REQ-025 When no command is issued, ram_ce=0, ram_we=0, and the address, sel and data outputs SHALL be driven to 0.
REQ-026 pN_rdata SHALL be 0 whenever pN_rvalid=0.
REQ-027 sel=0 with we=1 SHALL still issue (RAM no-op) and occupy one slot.

Reset
REQ-028 Asynchronous reset SHALL force: FSM to IDLE, hold register invalid, tags cleared, all outputs 0.
REQ-029 Reset asserted in HOLD2 SHALL drop the held request, with no RAM command issued for it and no rvalid for it.
REQ-030 A load issued in the cycle before reset assertion SHALL produce no rvalid.

Configuration
REQ-031 Macro DRAM_ARB_STATS_EN defined: 32-bit outputs stat_conflicts (count of IDLE->HOLD2 transitions) and stat_grants (count of issued commands), saturating at 0xFFFFFFFF, cleared by reset.
REQ-032 Macro DRAM_ARB_STATS_EN undefined: the stat ports and counters SHALL be absent; behaviour is otherwise identical.

Structure
REQ-033 Shared package SHALL hold the FSM state encoding, the request struct (we, addr, sel, wdata) and the owner-tag constants OWN_NONE, OWN_P1 and OWN_P2.
REQ-034 One sub-module dram_req_slot SHALL implement the single-entry hold register (load, clear, valid, payload).

Verification
REQ-035 p1 load addr 0x1c000010 alone -> ram_ce=1, we=0 same cycle; next cycle p1_rvalid=1 with RAM data; p2_rvalid=0.
REQ-036 Both valid, p1 store 0xDEADBEEF sel 0xF to 0x100, p2 load 0x100 -> cycle0 RAM store, both ready; cycle1 RAM load, ready=0; cycle2 p2_rdata=0xDEADBEEF.
REQ-037 Both valid for 4 consecutive cycles -> readies toggle 1,0,1,0; 4 RAM commands in p1,p2,p1,p2 order.
REQ-038 reset_n pulsed low mid-HOLD2 -> no held command issued, all rvalid 0, FSM IDLE after release.
REQ-039 With DRAM_ARB_STATS_EN defined, 3 conflicts plus 2 single requests -> stat_conflicts=3, stat_grants=8.
REQ-040 Idle bus -> ram_ce=0 and all RAM outputs 0 every cycle.
